// File: rtl/uart_tx_serializer_if.sv
// Bus between the TX sequencer (master) and the UART serializer (slave).
//   data      master->slave  byte to transmit, sampled only on an accepted send
//   send      master->slave  start request; a request is accepted on any rising
//                            clk edge where send = 1 and the serializer is idle
//                            (busy = 0). Requests while busy are dropped, not queued.
//   tx        slave->master  serial line, idle high
//   done_tx   slave->master  1-cycle pulse when the stop bit has completed
//   busy      slave->master  high while a frame is in flight
//   state_dbg slave->master  current FSM state, for observation only
interface uart_tx_serializer_if;
  logic [7:0] data;
  logic       send;
  logic       tx;
  logic       done_tx;
  logic       busy;
  logic [2:0] state_dbg;

  modport master (
    output data, send,
    input  tx, done_tx, busy, state_dbg
  );

  modport slave (
    input  data, send,
    output tx, done_tx, busy, state_dbg
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter: latches one byte on an accepted send and shifts it onto tx
// as start + 8 data bits (LSB first) + optional parity + stop, then pulses
// done_tx for one cycle on return to idle.
// Ports:
//   clk    system clock, all logic on posedge
//   reset  synchronous, active-high; aborts any frame, tx returns high next cycle
//   bus    uart_tx_serializer_if.slave (data, send, tx, done_tx, busy, state_dbg)
// Parameters:
//   CLKS_PER_BIT  clk cycles per bit, >= 2
//   PARITY        0 = none, 1 = even, 2 = odd
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int PARITY       = 0
) (
  input logic                 clk,
  input logic                 reset,
  uart_tx_serializer_if.slave bus
);

  generate
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
    end
  endgenerate

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          tx_q;
  logic          done_q;
  logic          busy_q;
  logic          parity_bit;
  logic          bit_end;

  // Parity is taken from the latched byte, so data changes after accept
  // cannot alter it.
  assign parity_bit = (PARITY == 2) ? ~^shift_reg : ^shift_reg;
  assign bit_end    = (cnt == CNT_MAX);

  // tx is registered and loaded with the next bit's level on the same edge
  // the state advances, so the line changes exactly at each bit boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx_q    <= 1'b1;
          cnt     <= '0;
          bit_idx <= '0;
          if (bus.send) begin
            shift_reg <= bus.data;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx_q    <= shift_reg[0];
            state   <= ST_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              if (PARITY != 0) begin
                tx_q  <= parity_bit;
                state <= ST_PARITY;
              end else begin
                tx_q  <= 1'b1;
                state <= ST_STOP;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= shift_reg[bit_idx + 3'd1];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            cnt   <= '0;
            tx_q  <= 1'b1;
            state <= ST_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            cnt    <= '0;
            tx_q   <= 1'b1;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          cnt    <= '0;
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tx        = tx_q;
  assign bus.done_tx   = done_q;
  assign bus.busy      = busy_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer with CLKS_PER_BIT = 4: three instances (no,
// even, odd parity). Frames are checked cycle by cycle against hand-written
// line patterns, where bit time b of the pattern is the expected tx level.
module tb_uart_tx_serializer;
  localparam int CPB = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  uart_tx_serializer_if if0 ();
  uart_tx_serializer_if if1 ();
  uart_tx_serializer_if if2 ();

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(0)) u_dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(2)) u_dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;     // instance: 0 none, 1 even, 2 odd
    logic [7:0]  data;
    int          nbits;   // 10 or 11 bit times
    logic [10:0] exp;     // exp[b] = expected tx during bit time b
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] get_out(input int sel, input int which);
    logic tx, dn, bs;
    logic [2:0] st;
    case (sel)
      1:       begin tx = if1.tx; dn = if1.done_tx; bs = if1.busy; st = if1.state_dbg; end
      2:       begin tx = if2.tx; dn = if2.done_tx; bs = if2.busy; st = if2.state_dbg; end
      default: begin tx = if0.tx; dn = if0.done_tx; bs = if0.busy; st = if0.state_dbg; end
    endcase
    case (which)
      0:       return {7'd0, tx};
      1:       return {7'd0, dn};
      2:       return {7'd0, bs};
      default: return {5'd0, st};
    endcase
  endfunction

  // driver
  task automatic drive(input int sel, input logic snd, input logic [7:0] d);
    case (sel)
      1:       begin if1.send = snd; if1.data = d; end
      2:       begin if2.send = snd; if2.data = d; end
      default: begin if0.send = snd; if0.data = d; end
    endcase
  endtask

  task automatic set_send(input int sel, input logic snd);
    case (sel)
      1:       if1.send = snd;
      2:       if2.send = snd;
      default: if0.send = snd;
    endcase
  endtask

  // Pulse (or hold) send so it is sampled on the next edge.
  task automatic start_send(input int sel, input logic [7:0] d, input bit hold);
    drive(sel, 1'b1, d);
    tick();
    if (!hold) set_send(sel, 1'b0);
  endtask

  // Called right after the accept edge. Checks every cycle of the frame and
  // returns in the done_tx cycle. If disturb >= 0, a send with data 0xFF is
  // pulsed at that cycle of the frame and data is left at 0xFF.
  task automatic check_body(input int sel, input int nbits, input logic [10:0] exp,
                            input int disturb);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < CPB; c++) begin
        chk("tx_bit", get_out(sel, 0), {7'd0, exp[b]});
        chk("busy_in_frame", get_out(sel, 2), 8'd1);
        chk("done_in_frame", get_out(sel, 1), 8'd0);
        if (b * CPB + c == disturb) drive(sel, 1'b1, 8'hFF);
        else if (disturb >= 0 && b * CPB + c == disturb + 1) set_send(sel, 1'b0);
        tick();
      end
    end
    chk("done_pulse", get_out(sel, 1), 8'd1);
    chk("busy_at_done", get_out(sel, 2), 8'd0);
    chk("tx_at_done", get_out(sel, 0), 8'd1);
    chk("state_at_done", get_out(sel, 3), 8'd0);
  endtask

  task automatic check_quiet(input int sel, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      chk("quiet_tx", get_out(sel, 0), 8'd1);
      chk("quiet_done", get_out(sel, 1), 8'd0);
      chk("quiet_busy", get_out(sel, 2), 8'd0);
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    // start 0, data LSB first, [parity], stop 1
    vecs[0] = '{0, 8'hA5, 10, 11'b0_1_10100101_0};
    vecs[1] = '{1, 8'h07, 11, 11'b1_1_00000111_0};
    vecs[2] = '{2, 8'h07, 11, 11'b1_0_00000111_0};
    vecs[3] = '{0, 8'hC3, 10, 11'b0_1_11000011_0};

    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    drive(2, 1'b0, 8'h00);
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    for (int s = 0; s < 3; s++) begin
      chk("rst_tx", get_out(s, 0), 8'd1);
      chk("rst_done", get_out(s, 1), 8'd0);
      chk("rst_busy", get_out(s, 2), 8'd0);
      chk("rst_state", get_out(s, 3), 8'd0);
    end
    tick();

    // table-driven frames (tests 1 and 2)
    for (int i = 0; i < 4; i++) begin
      start_send(vecs[i].sel, vecs[i].data, 1'b0);
      check_body(vecs[i].sel, vecs[i].nbits, vecs[i].exp, -1);
      tick();
      check_quiet(vecs[i].sel, 3);
    end

    // test 3: sequencer pairing, second send accepted 2 clks after done_tx
    start_send(0, 8'h12, 1'b0);
    check_body(0, 10, 11'b0_1_00010010_0, -1);
    tick();
    chk("pair_gap_done", get_out(0, 1), 8'd0);
    chk("pair_gap_tx", get_out(0, 0), 8'd1);
    start_send(0, 8'h34, 1'b0);
    check_body(0, 10, 11'b0_1_00110100_0, -1);
    tick();
    check_quiet(0, 3);

    // test 4: send 0xFF mid-frame is ignored, frame stays 0x55
    start_send(0, 8'h55, 1'b0);
    check_body(0, 10, 11'b0_1_01010101_0, 14);
    tick();
    check_quiet(0, 8);

    // test 5: reset 3 clks into data bit 2
    start_send(0, 8'hA5, 1'b0);
    repeat (CPB * 3 + 3) tick();
    chk("pre_rst_state", get_out(0, 3), 8'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_tx", get_out(0, 0), 8'd1);
    chk("abort_busy", get_out(0, 2), 8'd0);
    chk("abort_done", get_out(0, 1), 8'd0);
    chk("abort_state", get_out(0, 3), 8'd0);
    tick();
    check_quiet(0, 50);
    start_send(0, 8'h3C, 1'b0);
    check_body(0, 10, 11'b0_1_00111100_0, -1);
    tick();
    check_quiet(0, 2);

    // test 6: send held high across done_tx restarts on the done cycle
    start_send(0, 8'h81, 1'b1);
    check_body(0, 10, 11'b0_1_10000001_0, -1);
    tick();
    set_send(0, 1'b0);
    check_body(0, 10, 11'b0_1_10000001_0, -1);
    tick();
    check_quiet(0, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
